// File: rtl/mmio_timer_led_if.sv
// Memory-mapped bus between the core and the timer/LED block.
// The core drives the strobe, direction, address and write data.
// The block returns registered read data.
interface mmio_timer_led_if;
  logic        ce;
  logic        wre;
  logic [7:0]  ad;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output ce, output wre, output ad, output din, input dout);
  modport slave  (input ce, input wre, input ad, input din, output dout);
endinterface

// File: rtl/mmio_timer_led.sv
// Memory-mapped LED driver with a prescaled 32-bit timer.
// The timer has a compare match flag and an interrupt.
// Register index (ad[3:0]):
//   0 LED, 1 TIMER, 2 COMPARE, 3 STATUS, 4 CTRL, 5 SCRATCH.
// Read data is registered, so it appears one cycle after the access.
module mmio_timer_led #(
  parameter logic [3:0]  BASE     = 4'hF,
  parameter int unsigned PRESCALE = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_timer_led_if.slave      bus,
  output logic [5:0]           leds,
  output logic                 irq
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  localparam logic [3:0] IDX_LED     = 4'd0;
  localparam logic [3:0] IDX_TIMER   = 4'd1;
  localparam logic [3:0] IDX_COMPARE = 4'd2;
  localparam logic [3:0] IDX_STATUS  = 4'd3;
  localparam logic [3:0] IDX_CTRL    = 4'd4;
  localparam logic [3:0] IDX_SCRATCH = 4'd5;

  logic [5:0]  led;
  logic [31:0] timer;
  logic [15:0] pre;
  logic [31:0] compare;
  logic        match;
  logic        en;
  logic        irqen;
  logic [31:0] scratch;
  logic [31:0] rdata;

  logic        access;
  logic        wr;
  logic        rd;
  logic [3:0]  idx;
  logic        tick;
  logic        timer_wr;
  logic [31:0] timer_inc;
  logic        match_set;
  logic        match_clr;
  logic [31:0] rdata_nxt;

  assign access = bus.ce && (bus.ad[7:4] == BASE);
  assign wr     = access && bus.wre;
  assign rd     = access && !bus.wre;
  assign idx    = bus.ad[3:0];

  // Tick generation and match detection.
  // A TIMER write on a tick edge wins and suppresses match evaluation.
  // A match set on the same edge as a STATUS clear wins over the clear.
  always_comb begin
    tick      = en && (pre == PRE_LAST);
    timer_wr  = wr && (idx == IDX_TIMER);
    timer_inc = timer + 32'd1;
    match_set = tick && !timer_wr && (timer_inc == compare);
    match_clr = wr && (idx == IDX_STATUS) && bus.din[0];
  end

  // Read mux. Unmapped indices and unused upper bits read as zero.
  // TIMER returns the count before any increment on this edge.
  always_comb begin
    rdata_nxt = '0;
    case (idx)
      IDX_LED:     rdata_nxt = {26'd0, led};
      IDX_TIMER:   rdata_nxt = timer;
      IDX_COMPARE: rdata_nxt = compare;
      IDX_STATUS:  rdata_nxt = {31'd0, match};
      IDX_CTRL:    rdata_nxt = {30'd0, irqen, en};
      IDX_SCRATCH: rdata_nxt = scratch;
      default:     rdata_nxt = '0;
    endcase
  end

  // Prescaler: counts 0..PRESCALE-1 while enabled, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (en) begin
      if (tick) pre <= '0;
      else      pre <= pre + 16'd1;
    end
  end

  // Timer: any write clears it; otherwise it advances on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (timer_wr) begin
      timer <= '0;
    end else if (tick) begin
      timer <= timer_inc;
    end
  end

  // Sticky match flag with write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else if (match_set) begin
      match <= 1'b1;
    end else if (match_clr) begin
      match <= 1'b0;
    end
  end

  // Plain read/write registers: LED, COMPARE, CTRL and SCRATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led     <= '0;
      compare <= 32'hFFFF_FFFF;
      en      <= 1'b0;
      irqen   <= 1'b0;
      scratch <= '0;
    end else if (wr) begin
      case (idx)
        IDX_LED:     led     <= bus.din[5:0];
        IDX_COMPARE: compare <= bus.din;
        IDX_CTRL: begin
          en    <= bus.din[0];
          irqen <= bus.din[1];
        end
        IDX_SCRATCH: scratch <= bus.din;
        default: ;
      endcase
    end
  end

  // Registered read data, held between read accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd) begin
      rdata <= rdata_nxt;
    end
  end

  assign bus.dout = rdata;
  assign leds     = led;
  assign irq      = match && irqen;

endmodule

// File: tb/tb_mmio_timer_led.sv
// Directed testbench for mmio_timer_led, instantiated with PRESCALE=4.
// Each scenario task drives the bus and checks against hand-computed values.
module tb_mmio_timer_led;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] leds;
  logic irq;
  int checks = 0;
  int errors = 0;

  mmio_timer_led_if bus ();

  mmio_timer_led #(.BASE(4'hF), .PRESCALE(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .leds (leds),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Each bus helper starts and ends 1 time unit after a posedge.
  // Each helper consumes exactly one clock edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.ce = 1'b1; bus.wre = 1'b1; bus.ad = a; bus.din = d;
    @(posedge clk); #1;
    bus.ce = 1'b0; bus.wre = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.ce = 1'b1; bus.wre = 1'b0; bus.ad = a;
    @(posedge clk); #1;
    bus.ce = 1'b0;
    d = bus.dout;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ce = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rd(8'hF2, d);
    rst = 1'b1;
    #1;
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL rst_async_dout: got %h expected %h", bus.dout, 32'h0); end
    checks++; if (leds !== 6'h0) begin errors++; $display("FAIL rst_leds: got %h expected %h", leds, 6'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected %b", irq, 1'b0); end
    @(posedge clk); #1;
    rst = 1'b0;
    rd(8'hF1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_timer: got %h expected %h", d, 32'h0); end
    rd(8'hF2, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_compare: got %h expected %h", d, 32'hFFFF_FFFF); end
    rd(8'hF3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected %h", d, 32'h0); end
    rd(8'hF4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected %h", d, 32'h0); end
    rd(8'hF5, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_scratch: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    do_reset();
    bus.ce = 1'b1; bus.wre = 1'b1; bus.ad = 8'hF5; bus.din = 32'hAAAA_5555;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    bus.ce = 1'b0; bus.wre = 1'b0;
    rst = 1'b0;
    rd(8'hF5, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_aborted: got %h expected %h", d, 32'h0); end
    wr(8'hF5, 32'h1234_5678);
    rd(8'hF5, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL midrst_after: got %h expected %h", d, 32'h1234_5678); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    do_reset();
    wr(8'hF0, 32'hFFFF_FF2A);
    checks++; if (leds !== 6'h2A) begin errors++; $display("FAIL led_drive: got %h expected %h", leds, 6'h2A); end
    rd(8'hF0, d);
    checks++; if (d !== 32'h0000_002A) begin errors++; $display("FAIL led_read: got %h expected %h", d, 32'h0000_002A); end
  endtask

  task automatic test_timer_run();
    logic [31:0] d;
    do_reset();
    wr(8'hF4, 32'h1);
    idle(12);
    rd(8'hF1, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL timer_count: got %0d expected %0d", d, 3); end
    wr(8'hF4, 32'h0);
    idle(20);
    rd(8'hF1, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL timer_hold: got %0d expected %0d", d, 3); end
    rd(8'hF4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_match_irq();
    logic [31:0] d;
    do_reset();
    wr(8'hF2, 32'd2);
    wr(8'hF4, 32'h3);
    idle(7);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected %b", irq, 1'b0); end
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_8: got %b expected %b", irq, 1'b1); end
    wr(8'hF3, 32'h0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL status_w0_keeps: got %b expected %b", irq, 1'b1); end
    rd(8'hF3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL status_read: got %h expected %h", d, 32'h1); end
    wr(8'hF3, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected %b", irq, 1'b0); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    do_reset();
    force dut.timer = 32'hFFFF_FFFF;
    #2;
    release dut.timer;
    wr(8'hF2, 32'h0);
    wr(8'hF4, 32'h1);
    idle(3);
    rd(8'hF1, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre: got %h expected %h", d, 32'hFFFF_FFFF); end
    rd(8'hF3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL wrap_match: got %h expected %h", d, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_masked: got %b expected %b", irq, 1'b0); end
    rd(8'hF1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    do_reset();
    wr(8'hF2, 32'd1);
    wr(8'hF4, 32'h1);
    idle(3);
    wr(8'hF1, 32'h5555_5555);
    rd(8'hF3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL twrite_tick_nomatch: got %h expected %h", d, 32'h0); end
    rd(8'hF1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL twrite_tick_zero: got %h expected %h", d, 32'h0); end
    idle(1);
    wr(8'hF3, 32'h1);
    rd(8'hF3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL set_beats_clear: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    do_reset();
    wr(8'hF5, 32'h0000_1234);
    wr(8'hE3, 32'h0000_0001);
    wr(8'hE5, 32'hDEAD_BEEF);
    wr(8'hE0, 32'h0000_003F);
    wr(8'hE4, 32'h0000_0003);
    wr(8'hF9, 32'hFFFF_FFFF);
    checks++; if (leds !== 6'h0) begin errors++; $display("FAIL decode_leds: got %h expected %h", leds, 6'h0); end
    rd(8'hF5, d);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL decode_scratch: got %h expected %h", d, 32'h0000_1234); end
    rd(8'hE5, d);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL decode_dout_hold: got %h expected %h", d, 32'h0000_1234); end
    rd(8'hF4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL decode_ctrl: got %h expected %h", d, 32'h0); end
    rd(8'hF9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected %h", d, 32'h0); end
    wr(8'hF5, 32'hDEAD_BEEF);
    rd(8'hF5, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_rw: got %h expected %h", d, 32'hDEAD_BEEF); end
  endtask

  initial begin
    bus.ce = 1'b0; bus.wre = 1'b0; bus.ad = 8'h0; bus.din = 32'h0;
    #2 rst = 1'b1;
    #1;
    checks++; if (leds !== 6'h0) begin errors++; $display("FAIL por_leds: got %h expected %h", leds, 6'h0); end
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL por_dout: got %h expected %h", bus.dout, 32'h0); end
    @(posedge clk); #1;
    rst = 1'b0;
    test_reset();
    test_reset_mid_access();
    test_led();
    test_timer_run();
    test_match_irq();
    test_wrap();
    test_collisions();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmio_timer_led.md
MMIO_TIMER_LED -- requirements
Module: mmio_timer_led

Interface
REQ-001 Parameter BASE, default 4'hF, value of ad[7:4] that selects this block.
REQ-002 Parameter PRESCALE, default 27, clk cycles per timer tick (range 1..65535).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ce  input  1  bus access strobe from the core.
REQ-006 wre  input  1  1 = write, 0 = read; valid only while ce=1.
REQ-007 ad  input  8  word address; ad[7:4] is the block select, ad[3:0] is the register index.
REQ-008 din  input  32  write data.
REQ-009 dout  output  32  registered read data.
REQ-010 leds  output  6  LED drive, equal to LED[5:0].
REQ-011 irq  output  1  interrupt, equal to STATUS.match AND CTRL.irqen.

Function
REQ-012 The block SHALL act as a bus responder: an access is a cycle with ce=1 and ad[7:4]=BASE; any other cycle SHALL leave all state and dout unchanged.
REQ-013 Register map by ad[3:0]: 0 LED (RW, bits[5:0]; upper bits read 0); 1 TIMER (RO count, any write clears it to 0); 2 COMPARE (RW, 32 bits); 3 STATUS (bit0 match sticky, write-1-to-clear; other bits read 0); 4 CTRL (RW, bit0 en, bit1 irqen; upper bits read 0); 5 SCRATCH (RW, 32 bits); 6..15 unmapped.
REQ-014 A write SHALL update the addressed register at the posedge where the access is sampled; a write to an unmapped index SHALL have no effect.
REQ-015 A read SHALL load dout at the posedge where the access is sampled, so data is visible one cycle after the access (one-cycle latency, matching the core's memory timing).
REQ-016 dout SHALL hold its last value until the next read access; a read of an unmapped index SHALL return 32'h0.
REQ-017 A read of TIMER SHALL return the count value before that edge's increment.
REQ-018 While CTRL.en=1 the prescaler SHALL count 0..PRESCALE-1; at PRESCALE-1 it SHALL wrap to 0 and produce a tick.
REQ-019 While CTRL.en=0 the prescaler and TIMER SHALL hold their values.
REQ-020 On each tick TIMER SHALL increment by 1 modulo 2^32; 32'hFFFFFFFF SHALL wrap to 0.
REQ-021 STATUS.match SHALL set on the edge where TIMER takes a new value equal to COMPARE via a tick; a direct write to TIMER or COMPARE SHALL NOT set it.
REQ-022 Simultaneous write to TIMER and a tick: the write SHALL win, TIMER=0, and no match SHALL be evaluated.
REQ-023 Simultaneous write-1 to STATUS.match and a new match: set SHALL win, match=1.
REQ-024 A write of 0 to STATUS.bit0 SHALL leave match unchanged.
REQ-025 irq and leds SHALL be combinational from registers, with no extra latency.

Reset
REQ-026 While rst=1, asynchronously: LED=0, TIMER=0, prescaler=0, COMPARE=32'hFFFFFFFF, STATUS=0, CTRL=0, SCRATCH=0, dout=0, hence leds=0 and irq=0.
REQ-027 Reset asserted mid-access SHALL abort the access; the first access sampled after deassertion SHALL behave normally.

Verification
REQ-028 Reset, then write LED=32'hFFFF_FF2A (ad=8'hF0) -> leds=6'h2A next cycle; read ad=8'hF0 -> dout=32'h0000_002A one cycle later.
REQ-029 PRESCALE=4, write CTRL=1, then idle 12 cycles -> TIMER reads 3; write CTRL=0 -> TIMER stays at 3 over 20 further cycles.
REQ-030 COMPARE=2, CTRL=3, PRESCALE=4 -> STATUS=1 and irq=1 exactly 8 cycles after the CTRL write; write STATUS=1 -> irq=0.
REQ-031 Force TIMER near wrap (COMPARE=0, 2^32 ticks, or a bench backdoor setting TIMER=32'hFFFFFFFF) -> next tick gives TIMER=0 and sets match.
REQ-032 Write TIMER on a tick edge -> TIMER=0 with no match; write STATUS=1 on a match edge -> STATUS stays 1.
REQ-033 Accesses with ad=8'hE3, and a read of ad=8'hF9 -> no state change for the first; dout=0 for the read; SCRATCH write/readback of 32'hDEAD_BEEF returns 32'hDEAD_BEEF.
